// File: rtl/alarm_pkg.sv
// Shared widths and slot state encoding for the alarm bank.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RING = 2'd1,
    ST_SNZ  = 2'd2
  } slot_state_t;

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: stored configuration, IDLE/RINGING/SNOOZED FSM and its
// ring/snooze countdowns. Current state is exported for the bank and for
// debug observation.
module alarm_slot
  import alarm_pkg::*;
#(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  input  logic              wr_en,
  input  logic [HOUR_W-1:0] wr_hour,
  input  logic [MIN_W-1:0]  wr_min,
  input  logic [SEC_W-1:0]  wr_sec,
  input  logic              wr_enable,
  input  logic              snooze,
  input  logic              stop,
  output logic [HOUR_W-1:0] cfg_hour,
  output logic [MIN_W-1:0]  cfg_min,
  output logic [SEC_W-1:0]  cfg_sec,
  output logic              cfg_enable,
  output slot_state_t       state
);

  localparam int RC_RAW = $clog2(RING_SECONDS + 1);
  localparam int SC_RAW = $clog2(SNOOZE_SECONDS + 1);
  localparam int SN_RAW = $clog2(MAX_SNOOZE + 1);
  localparam int RC_W   = (RC_RAW < 1) ? 1 : RC_RAW;
  localparam int SC_W   = (SC_RAW < 1) ? 1 : SC_RAW;
  localparam int SN_W   = (SN_RAW < 1) ? 1 : SN_RAW;

  localparam logic [RC_W-1:0] RING_LOAD = RC_W'(RING_SECONDS);
  localparam logic [SC_W-1:0] SNZ_LOAD  = SC_W'(SNOOZE_SECONDS);
  localparam logic [SN_W-1:0] SNZ_MAX   = SN_W'(MAX_SNOOZE);

  slot_state_t       state_d;
  logic [RC_W-1:0]   ring_cnt, ring_cnt_d;
  logic [SC_W-1:0]   snz_cnt, snz_cnt_d;
  logic [SN_W-1:0]   snz_num, snz_num_d;
  logic [HOUR_W-1:0] cfg_hour_d;
  logic [MIN_W-1:0]  cfg_min_d;
  logic [SEC_W-1:0]  cfg_sec_d;
  logic              cfg_enable_d;
  logic              match;

  // Exact time equality against the armed configuration.
  assign match = cfg_enable && (cur_hour == cfg_hour) &&
                 (cur_min == cfg_min) && (cur_sec == cfg_sec);

  // Next-state logic; a write overrides everything, then stop, snooze, tick.
  always_comb begin
    state_d      = state;
    ring_cnt_d   = ring_cnt;
    snz_cnt_d    = snz_cnt;
    snz_num_d    = snz_num;
    cfg_hour_d   = cfg_hour;
    cfg_min_d    = cfg_min;
    cfg_sec_d    = cfg_sec;
    cfg_enable_d = cfg_enable;
    if (wr_en) begin
      state_d      = ST_IDLE;
      ring_cnt_d   = '0;
      snz_cnt_d    = '0;
      snz_num_d    = '0;
      cfg_hour_d   = wr_hour;
      cfg_min_d    = wr_min;
      cfg_sec_d    = wr_sec;
      cfg_enable_d = wr_enable;
    end else begin
      case (state)
        ST_IDLE: begin
          // Match is only looked at from IDLE, so a slot that just stopped
          // cannot retrigger within the same second.
          if (sec_tick && match) begin
            state_d    = ST_RING;
            ring_cnt_d = RING_LOAD;
            snz_num_d  = '0;
          end
        end
        ST_RING: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (snooze) begin
            if (snz_num < SNZ_MAX) begin
              state_d   = ST_SNZ;
              snz_cnt_d = SNZ_LOAD;
              snz_num_d = snz_num + SN_W'(1);
            end else begin
              state_d = ST_IDLE;
            end
          end else if (sec_tick) begin
            ring_cnt_d = (ring_cnt == '0) ? '0 : ring_cnt - RC_W'(1);
            if (ring_cnt <= RC_W'(1)) state_d = ST_IDLE;
          end
        end
        ST_SNZ: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else if (sec_tick) begin
            snz_cnt_d = (snz_cnt == '0) ? '0 : snz_cnt - SC_W'(1);
            if (snz_cnt <= SC_W'(1)) begin
              state_d    = ST_RING;
              ring_cnt_d = RING_LOAD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ring_cnt   <= '0;
      snz_cnt    <= '0;
      snz_num    <= '0;
      cfg_hour   <= '0;
      cfg_min    <= '0;
      cfg_sec    <= '0;
      cfg_enable <= 1'b0;
    end else begin
      state      <= state_d;
      ring_cnt   <= ring_cnt_d;
      snz_cnt    <= snz_cnt_d;
      snz_num    <= snz_num_d;
      cfg_hour   <= cfg_hour_d;
      cfg_min    <= cfg_min_d;
      cfg_sec    <= cfg_sec_d;
      cfg_enable <= cfg_enable_d;
    end
  end

endmodule

// File: rtl/alarm_bank.sv
// Bank of independent alarm slots: write decode, registered read-back mux,
// combined ring request and lowest-index ringing slot encoder.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sec_tick,
  input  logic [HOUR_W-1:0]     cur_hour,
  input  logic [MIN_W-1:0]      cur_min,
  input  logic [SEC_W-1:0]      cur_sec,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [HOUR_W-1:0]     wr_hour,
  input  logic [MIN_W-1:0]      wr_min,
  input  logic [SEC_W-1:0]      wr_sec,
  input  logic                  wr_enable,
  input  logic                  snooze,
  input  logic                  stop,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [HOUR_W-1:0]     rd_hour,
  output logic [MIN_W-1:0]      rd_min,
  output logic [SEC_W-1:0]      rd_sec,
  output logic                  rd_enable,
  output logic                  ring,
  output logic [IDX_W-1:0]      ring_idx,
  output logic [NUM_ALARMS-1:0] ringing_mask,
  output logic [NUM_ALARMS-1:0] snoozed_mask
);

  logic [HOUR_W-1:0] slot_hour   [NUM_ALARMS];
  logic [MIN_W-1:0]  slot_min    [NUM_ALARMS];
  logic [SEC_W-1:0]  slot_sec    [NUM_ALARMS];
  logic              slot_enable [NUM_ALARMS];
  slot_state_t       slot_state  [NUM_ALARMS];

  logic [HOUR_W-1:0] rd_hour_d;
  logic [MIN_W-1:0]  rd_min_d;
  logic [SEC_W-1:0]  rd_sec_d;
  logic              rd_enable_d;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    alarm_slot #(
      .RING_SECONDS   (RING_SECONDS),
      .SNOOZE_SECONDS (SNOOZE_SECONDS),
      .MAX_SNOOZE     (MAX_SNOOZE)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .sec_tick   (sec_tick),
      .cur_hour   (cur_hour),
      .cur_min    (cur_min),
      .cur_sec    (cur_sec),
      .wr_en      (wr_en && (wr_idx == IDX_W'(i))),
      .wr_hour    (wr_hour),
      .wr_min     (wr_min),
      .wr_sec     (wr_sec),
      .wr_enable  (wr_enable),
      .snooze     (snooze),
      .stop       (stop),
      .cfg_hour   (slot_hour[i]),
      .cfg_min    (slot_min[i]),
      .cfg_sec    (slot_sec[i]),
      .cfg_enable (slot_enable[i]),
      .state      (slot_state[i])
    );
    assign ringing_mask[i] = (slot_state[i] == ST_RING);
    assign snoozed_mask[i] = (slot_state[i] == ST_SNZ);
  end

  assign ring = |ringing_mask;

  // Lowest-index ringing slot wins; zero when nothing rings.
  always_comb begin
    ring_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (ringing_mask[i]) ring_idx = IDX_W'(i);
    end
  end

  // Read-back select; an index beyond the last slot reads as zeros.
  always_comb begin
    rd_hour_d   = '0;
    rd_min_d    = '0;
    rd_sec_d    = '0;
    rd_enable_d = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_hour_d   = slot_hour[i];
        rd_min_d    = slot_min[i];
        rd_sec_d    = slot_sec[i];
        rd_enable_d = slot_enable[i];
      end
    end
  end

  // Read-back register, one cycle behind rd_idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_hour   <= '0;
      rd_min    <= '0;
      rd_sec    <= '0;
      rd_enable <= 1'b0;
    end else begin
      rd_hour   <= rd_hour_d;
      rd_min    <= rd_min_d;
      rd_sec    <= rd_sec_d;
      rd_enable <= rd_enable_d;
    end
  end

endmodule
